bist_signature_checker: RTL and testbench
=========================================

# bist_signature_checker

Response compactor and verdict stage of the per-scan BIST path, downstream of the CUT capture outputs (`cut_test_out`). It folds one captured response vector per valid cycle into a MISR, counts captured patterns, and, after the programmed pattern count, compares the signature against a golden constant. It drives `pass_nfail` and `bist_end` to the top level.

## Interface
- `WIDTH`, 16: MISR / signature width, ≥ 2.
- `DATA_W`, 2: captured response width; must be ≤ WIDTH.
- `POLY`, 16'h1021: feedback polynomial, WIDTH bits; bit i set means tap into bit i.
- `SEED`, 0: signature value loaded at start and at reset.
- `GOLDEN`, 0: expected final signature.
- `PATTERNS`, 32: number of captured vectors per run, ≥ 1.
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle request to begin a run.
- `capture_valid` in 1: `capture_data` is a valid CUT response this cycle.
- `capture_data` in DATA_W: CUT response vector.
- `signature` out WIDTH: current MISR contents.
- `busy` out 1: high in COMPACT and COMPARE.
- `bist_end` out 1: high in DONE.
- `pass_nfail` out 1: verdict; meaningful only while `bist_end`=1.

## Operation
- States are IDLE, COMPACT, COMPARE, DONE. Reset state is IDLE.
- **IDLE:**
  - `start`=1 goes to COMPACT.
  - `signature` loads SEED.
  - The pattern count clears to 0.
- **COMPACT:**
  - On each `capture_valid`=1, the MISR updates to `{sig[WIDTH-2:0],1'b0} ^ (sig[WIDTH-1] ? POLY : 0) ^ zero_extend(capture_data)`, and the count increments.
  - When `capture_valid`=1 and count==PATTERNS-1, go to COMPARE on the same edge.
  - `capture_valid`=0 holds all state; stalls of any length are legal.
- **COMPARE:** lasts one cycle. It registers `pass_nfail` = (signature==GOLDEN), then goes to DONE.
- **DONE:**
  - Holds `signature`, `pass_nfail` and `bist_end`=1 indefinitely.
  - `start`=1 restarts: goes to COMPACT, reloads SEED, clears the count, and clears `pass_nfail` and `bist_end`.
- Ignored inputs:
  - `start` is ignored in COMPACT and COMPARE.
  - `capture_valid` is ignored in IDLE, COMPARE and DONE, including the cycle `start` is accepted.
- Count width is $clog2(PATTERNS+1). The count never wraps; it stops at PATTERNS.
- Reset asserted in any state:
  - Next state is IDLE.
  - `signature`=SEED, `busy`=0, `bist_end`=0, `pass_nfail`=0.
  - Any run in progress is discarded.

## Timing
- Reset values: `signature`=SEED, `busy`=0, `bist_end`=0, `pass_nfail`=0.
- Start acceptance:
  - `start` sampled at edge E.
  - `busy`=1 from E.
  - The first capture that can be accepted is at edge E+1.
- Verdict latency:
  - Last capture accepted at edge N; `signature` shows the final value after N.
  - `pass_nfail` and `bist_end` rise at N+1; `busy` falls at N+1.
- Minimum run length: PATTERNS+2 cycles, from the `start` edge to `bist_end`.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: `BIST_SIG_XMASK_EN`.
- **Defined:**
  - Adds input `capture_mask` [DATA_W] (X-mask).
  - Bits with mask=1 are forced to 0 before the MISR XOR.
  - Masked bits still count toward nothing extra; counting is unchanged.
- **Undefined:** no port; all captured bits are folded.

## Structure
- Package `bist_pkg`:
  - State enum `sig_state_t` (IDLE, COMPACT, COMPARE, DONE).
  - A `misr_next` function (sig, data, poly) shared with the pattern-generator LFSR stage.
- One sub-module, `misr_reg`: a WIDTH-bit register with seed load, enable and the feedback update.
- The FSM, the counter and the compare stay in the top of the block.

## Test plan
All scenarios use WIDTH=8, DATA_W=2, POLY=8'h1D, SEED=8'h00, unless stated otherwise.

- **Reset values:** hold `reset`=0 for 3 cycles → `signature`=8'h00, `busy`=0, `bist_end`=0, `pass_nfail`=0.
- **Pass run:**
  - Setup: PATTERNS=2, GOLDEN=8'h01.
  - Stimulus: `start`, then captures 2'b01 and 2'b11 on consecutive cycles.
  - Response: `signature` goes 8'h01 then 8'h01; one cycle later `bist_end`=1 and `pass_nfail`=1.
- **Feedback tap and fail:**
  - Setup: SEED=8'h80, PATTERNS=1, GOLDEN=8'h00.
  - Stimulus: one capture of 2'b00.
  - Response: `signature`=8'h1D, `pass_nfail`=0, `bist_end`=1.
- **Stalls:** the pass run with 5 idle cycles between captures → identical signature and verdict; `bist_end` is delayed by exactly 5 cycles.
- **Ignored inputs and restart:**
  - `start` pulsed during COMPACT → no effect.
  - `capture_valid` during DONE → `signature` unchanged.
  - `start` in DONE → `bist_end` falls next cycle and `signature`=SEED.
- **Reset mid-run:** `reset`=0 after 1 of 2 captures → IDLE, `signature`=SEED; a following full run passes normally.

Source files
------------

// File: rtl/bist_pkg.sv
// bist_pkg: shared state enum and MISR/LFSR next-state function for the BIST path
package bist_pkg;
  localparam int MAX_W = 64;
  typedef enum logic [1:0] {IDLE, COMPACT, COMPARE, DONE} sig_state_t;
  // w selects which bit feeds back; callers cast the result back to their width
  function automatic logic [MAX_W-1:0] misr_next(input logic [MAX_W-1:0] sig, input logic [MAX_W-1:0] data,
                                                 input logic [MAX_W-1:0] poly, input int w);
    return {sig[MAX_W-2:0], 1'b0} ^ (sig[w-1] ? poly : '0) ^ data;
  endfunction
endpackage

// File: rtl/bist_signature_checker_misr_reg.sv
// misr_reg: WIDTH-bit MISR register with seed load, enable and feedback update
module misr_reg
  import bist_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DATA_W = 2,
  parameter logic [WIDTH-1:0] POLY = 16'h1021,
  parameter logic [WIDTH-1:0] SEED = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic [WIDTH-1:0]  q
);
  always_ff @(posedge clock)
    if (!reset || load) q <= SEED;
    else if (en) q <= WIDTH'(misr_next(MAX_W'(q), MAX_W'(data), MAX_W'(POLY), WIDTH));
endmodule

// File: rtl/bist_signature_checker.sv
// bist_signature_checker: MISR compaction, pattern counting and golden compare; BIST_SIG_XMASK_EN adds capture_mask
module bist_signature_checker
  import bist_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DATA_W = 2,
  parameter logic [WIDTH-1:0] POLY = 16'h1021,
  parameter logic [WIDTH-1:0] SEED = '0,
  parameter logic [WIDTH-1:0] GOLDEN = '0,
  parameter int PATTERNS = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              capture_valid,
`ifdef BIST_SIG_XMASK_EN
  input  logic [DATA_W-1:0] capture_mask,
`endif
  input  logic [DATA_W-1:0] capture_data,
  output logic [WIDTH-1:0]  signature,
  output logic              busy,
  output logic              bist_end,
  output logic              pass_nfail
);
  localparam int CW = $clog2(PATTERNS + 1);
  sig_state_t state;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] fold;
  logic load, en;
`ifdef BIST_SIG_XMASK_EN
  assign fold = capture_data & ~capture_mask;
`else
  assign fold = capture_data;
`endif
  assign load = state == IDLE || (state == DONE && start);
  assign en = state == COMPACT && capture_valid;
  misr_reg #(.WIDTH(WIDTH), .DATA_W(DATA_W), .POLY(POLY), .SEED(SEED)) u_misr (
    .clock(clock), .reset(reset), .load(load), .en(en), .data(fold), .q(signature)
  );
  always_ff @(posedge clock)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      busy <= 1'b0;
      bist_end <= 1'b0;
      pass_nfail <= 1'b0;
    end else
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start) begin
            state <= COMPACT;
            busy <= 1'b1;
          end
        end
        COMPACT: if (capture_valid) begin
          if (cnt != CW'(PATTERNS)) cnt <= cnt + 1'b1;
          if (cnt == CW'(PATTERNS - 1)) state <= COMPARE;
        end
        COMPARE: begin
          pass_nfail <= signature == GOLDEN;
          bist_end <= 1'b1;
          busy <= 1'b0;
          state <= DONE;
        end
        DONE: if (start) begin
          state <= COMPACT;
          cnt <= '0;
          pass_nfail <= 1'b0;
          bist_end <= 1'b0;
          busy <= 1'b1;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_bist_signature_checker.sv
// tb_bist_signature_checker: directed checks of compaction, verdict, stalls, ignored inputs and reset
module tb_bist_signature_checker;
  logic clock = 0;
  logic ra = 0, sa = 0, va = 0, rb = 0, sb = 0, vb = 0;
  logic [1:0] da = 0, db = 0;
  logic [7:0] sig_a, sig_b;
  logic busy_a, end_a, pn_a, busy_b, end_b, pn_b;
  int total = 0, bad = 0, lat;
  always #5 clock = ~clock;
  bist_signature_checker #(.WIDTH(8), .DATA_W(2), .POLY(8'h1D), .SEED(8'h00), .GOLDEN(8'h01), .PATTERNS(2)) dut_a (
    .clock(clock), .reset(ra), .start(sa), .capture_valid(va),
`ifdef BIST_SIG_XMASK_EN
    .capture_mask(2'b00),
`endif
    .capture_data(da), .signature(sig_a), .busy(busy_a), .bist_end(end_a), .pass_nfail(pn_a)
  );
  bist_signature_checker #(.WIDTH(8), .DATA_W(2), .POLY(8'h1D), .SEED(8'h80), .GOLDEN(8'h00), .PATTERNS(1)) dut_b (
    .clock(clock), .reset(rb), .start(sb), .capture_valid(vb),
`ifdef BIST_SIG_XMASK_EN
    .capture_mask(2'b00),
`endif
    .capture_data(db), .signature(sig_b), .busy(busy_b), .bist_end(end_b), .pass_nfail(pn_b)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic run_a(input int gap, output int l);
    sa = 1;
    step;
    sa = 0;
    l = 0;
    va = 1;
    da = 2'b01;
    step;
    l++;
    chk("sig_cap1", sig_a, 8'h01);
    va = 0;
    repeat (gap) begin
      step;
      l++;
    end
    va = 1;
    da = 2'b11;
    step;
    l++;
    chk("sig_cap2", sig_a, 8'h01);
    va = 0;
    while (!end_a && l < 50) begin
      step;
      l++;
    end
  endtask
  initial begin
    repeat (3) step;
    chk("rst_sig", sig_a, 8'h00);
    chk("rst_busy", busy_a, 0);
    chk("rst_end", end_a, 0);
    chk("rst_pn", pn_a, 0);
    ra = 1;
    rb = 1;
    sa = 1;
    step;
    chk("start_busy", busy_a, 1);
    sa = 0;
    va = 1;
    da = 2'b01;
    step;
    chk("pass_sig1", sig_a, 8'h01);
    da = 2'b11;
    step;
    chk("pass_sig2", sig_a, 8'h01);
    chk("pass_busy_compare", busy_a, 1);
    chk("pass_end_early", end_a, 0);
    va = 0;
    step;
    chk("pass_end", end_a, 1);
    chk("pass_pn", pn_a, 1);
    chk("pass_busy_fall", busy_a, 0);
    sb = 1;
    step;
    sb = 0;
    vb = 1;
    db = 2'b00;
    step;
    chk("fb_sig", sig_b, 8'h1D);
    vb = 0;
    step;
    chk("fb_end", end_b, 1);
    chk("fb_pn", pn_b, 0);
    run_a(0, lat);
    chk("base_lat", lat, 3);
    chk("base_pn", pn_a, 1);
    run_a(5, lat);
    chk("stall_lat", lat, 8);
    chk("stall_sig", sig_a, 8'h01);
    chk("stall_pn", pn_a, 1);
    sa = 1;
    step;
    chk("restart_end", end_a, 0);
    chk("restart_sig", sig_a, 8'h00);
    va = 1;
    da = 2'b01;
    step;
    sa = 0;
    chk("compact_start_sig", sig_a, 8'h01);
    chk("compact_start_busy", busy_a, 1);
    da = 2'b11;
    step;
    va = 0;
    step;
    chk("ign_end", end_a, 1);
    chk("ign_pn", pn_a, 1);
    va = 1;
    da = 2'b10;
    step;
    step;
    chk("done_cv_sig", sig_a, 8'h01);
    chk("done_cv_end", end_a, 1);
    sa = 1;
    step;
    sa = 0;
    chk("done_start_end", end_a, 0);
    chk("done_start_sig", sig_a, 8'h00);
    da = 2'b01;
    step;
    va = 0;
    chk("mid_sig", sig_a, 8'h01);
    ra = 0;
    step;
    chk("mid_rst_sig", sig_a, 8'h00);
    chk("mid_rst_busy", busy_a, 0);
    ra = 1;
    step;
    chk("idle_hold_busy", busy_a, 0);
    run_a(0, lat);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_end", end_a, 1);
    chk("post_rst_pn", pn_a, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
